partition_trace_gen: RTL and testbench

//  Sequential generator for the dynamic-partition fixpoint traces that the combinational trace checkers validate.

---
 rtl/dynpart_pkg.sv | 16 +
 rtl/trace_step.sv | 21 ++
 rtl/partition_trace_gen.sv | 110 +++++++++++
 tb/tb_partition_trace_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dynpart_pkg.sv
// Shared types and helpers for the dynamic-partition trace generator and its checkers.
package dynpart_pkg;

  localparam int unsigned DEF_CNT_W   = 3;
  localparam int unsigned DEF_PHASE_W = 2;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]   cnt;
    logic [DEF_PHASE_W-1:0] phase;
  } trace_state_t;

  function automatic logic states_equal(input trace_state_t a, input trace_state_t b);
    return (a.cnt == b.cnt) && (a.phase == b.phase);
  endfunction

endpackage

// File: rtl/trace_step.sv
// Combinational transition relation T(cnt, phase) of the dynamic-partition trace.
module trace_step
  import dynpart_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned PHASE_W = DEF_PHASE_W
) (
  input  logic [CNT_W-1:0]   cnt,
  input  logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   nxt_cnt,
  output logic [PHASE_W-1:0] nxt_phase
);

  logic inc;

  // Counter advances when the Johnson phase's end bits agree; wraps modulo 2^CNT_W.
  assign inc       = (phase[0] == phase[PHASE_W-1]);
  assign nxt_cnt   = cnt + CNT_W'(inc);
  assign nxt_phase = {phase[PHASE_W-2:0], ~phase[PHASE_W-1]};

endmodule

// File: rtl/partition_trace_gen.sv
// Streams the trace from a loaded initial state until it returns to that state or hits MAX_STEPS.
module partition_trace_gen
  import dynpart_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PHASE_W   = DEF_PHASE_W,
  parameter int unsigned MAX_STEPS = 20,
  localparam int unsigned STEP_W   = $clog2(MAX_STEPS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   init_cnt,
  input  logic [PHASE_W-1:0] init_phase,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_cnt,
  output logic [PHASE_W-1:0] out_phase,
  output logic [STEP_W-1:0]  out_step,
  output logic               done,
  output logic               cycle_found,
  output logic [STEP_W-1:0]  cycle_len
);

  typedef enum logic [1:0] {StIdle, StEmit, StFin} state_e;

  state_e               state;
  logic [CNT_W-1:0]     init_cnt_q;
  logic [PHASE_W-1:0]   init_phase_q;
  logic [CNT_W-1:0]     nxt_cnt;
  logic [PHASE_W-1:0]   nxt_phase;
  logic [STEP_W-1:0]    step_inc;
  logic                 fire;
  logic                 back_to_init;

  trace_step #(
    .CNT_W   (CNT_W),
    .PHASE_W (PHASE_W)
  ) u_trace_step (
    .cnt       (out_cnt),
    .phase     (out_phase),
    .nxt_cnt   (nxt_cnt),
    .nxt_phase (nxt_phase)
  );

  assign fire         = out_valid & out_ready;
  assign step_inc     = out_step + STEP_W'(1);
  assign back_to_init = (nxt_cnt == init_cnt_q) && (nxt_phase == init_phase_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StIdle;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      cycle_found  <= 1'b0;
      cycle_len    <= '0;
      out_cnt      <= '0;
      out_phase    <= '0;
      out_step     <= '0;
      init_cnt_q   <= '0;
      init_phase_q <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            init_cnt_q   <= init_cnt;
            init_phase_q <= init_phase;
            out_cnt      <= init_cnt;
            out_phase    <= init_phase;
            out_step     <= '0;
            out_valid    <= 1'b1;
            busy         <= 1'b1;
            cycle_found  <= 1'b0;
            cycle_len    <= '0;
            state        <= StEmit;
          end
        end
        StEmit: begin
          if (fire) begin
            if (back_to_init) begin
              // The returning initial state is reported via cycle_len, never emitted.
              cycle_found <= 1'b1;
              cycle_len   <= step_inc;
              out_valid   <= 1'b0;
              done        <= 1'b1;
              state       <= StFin;
            end else if (step_inc == STEP_W'(MAX_STEPS)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= StFin;
            end else begin
              out_cnt   <= nxt_cnt;
              out_phase <= nxt_phase;
              out_step  <= step_inc;
            end
          end
        end
        StFin: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_partition_trace_gen.sv
// Bench for partition_trace_gen: table vectors, random stalls/starts and reset abort vs. a trace model.
module tb_partition_trace_gen;
  import dynpart_pkg::*;

  localparam int CW = 3;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start1, start2, out_ready;
  logic [CW-1:0] init_cnt;
  logic [PW-1:0] init_phase;

  logic          busy1, valid1, done1, found1;
  logic [CW-1:0] cnt1;
  logic [PW-1:0] ph1;
  logic [4:0]    step1, len1;
  logic          busy2, valid2, done2, found2;
  logic [CW-1:0] cnt2;
  logic [PW-1:0] ph2;
  logic [3:0]    step2, len2;

  partition_trace_gen #(.CNT_W(CW), .PHASE_W(PW), .MAX_STEPS(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .init_cnt(init_cnt), .init_phase(init_phase),
    .busy(busy1), .out_valid(valid1), .out_ready(out_ready), .out_cnt(cnt1), .out_phase(ph1),
    .out_step(step1), .done(done1), .cycle_found(found1), .cycle_len(len1)
  );

  partition_trace_gen #(.CNT_W(CW), .PHASE_W(PW), .MAX_STEPS(12)) dut_short (
    .clk(clk), .rst_n(rst_n), .start(start2), .init_cnt(init_cnt), .init_phase(init_phase),
    .busy(busy2), .out_valid(valid2), .out_ready(out_ready), .out_cnt(cnt2), .out_phase(ph2),
    .out_step(step2), .done(done2), .cycle_found(found2), .cycle_len(len2)
  );

  bit sel;
  logic m_busy, m_valid, m_done, m_found;
  logic [CW-1:0] m_cnt;
  logic [PW-1:0] m_phase;
  logic [4:0] m_step, m_len;

  always_comb begin
    if (sel) begin
      m_busy = busy2; m_valid = valid2; m_done = done2; m_found = found2;
      m_cnt = cnt2; m_phase = ph2; m_step = {1'b0, step2}; m_len = {1'b0, len2};
    end else begin
      m_busy = busy1; m_valid = valid1; m_done = done1; m_found = found1;
      m_cnt = cnt1; m_phase = ph1; m_step = step1; m_len = len1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: next state from the transition rules, in plain integer arithmetic.
  function automatic trace_state_t model_next(input trace_state_t s);
    int c, p, msb, inc;
    trace_state_t r;
    c   = int'(s.cnt);
    p   = int'(s.phase);
    msb = (p >> (PW - 1)) & 1;
    inc = ((p & 1) == msb) ? 1 : 0;
    r.cnt   = CW'((c + inc) % (1 << CW));
    r.phase = PW'(((p << 1) % (1 << PW)) | (msb ^ 1));
    return r;
  endfunction

  trace_state_t exp_q[$];
  int           exp_len;

  task automatic build_model(input int ic, input int ip, input int maxs);
    trace_state_t ini, cur, nx;
    exp_q.delete();
    exp_len = 0;
    ini.cnt = CW'(ic);
    ini.phase = PW'(ip);
    cur = ini;
    forever begin
      exp_q.push_back(cur);
      nx = model_next(cur);
      if (states_equal(nx, ini)) begin
        exp_len = exp_q.size();
        break;
      end
      if (exp_q.size() == maxs) break;
      cur = nx;
    end
  endtask

  task automatic drive_start(input bit s, input logic v);
    if (s) start2 = v;
    else start1 = v;
  endtask

  // One complete run; returns the step-1 beat and the last accepted beat.
  task automatic run(input bit s, input int ic, input int ip, input int maxs, input bit rnd,
                     input bit pulse, output int s1c, output int s1p, output int lc, output int lp);
    int idx;
    bit fin;
    build_model(ic, ip, maxs);
    sel = s;
    s1c = -1; s1p = -1; lc = -1; lp = -1;
    @(negedge clk);
    init_cnt = CW'(ic);
    init_phase = PW'(ip);
    out_ready = 1'b1;
    drive_start(s, 1'b1);
    @(negedge clk);
    drive_start(s, 1'b0);
    init_cnt = CW'($urandom);
    init_phase = PW'($urandom);
    check("start_clears_found", int'(m_found), 0);
    check("start_clears_len", int'(m_len), 0);
    check("busy_after_start", int'(m_busy), 1);
    idx = 0;
    fin = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (m_done) begin
        fin = 1;
      end else begin
        check("valid_in_emit", int'(m_valid), 1);
        if (idx < exp_q.size()) begin
          check("beat_cnt", int'(m_cnt), int'(exp_q[idx].cnt));
          check("beat_phase", int'(m_phase), int'(exp_q[idx].phase));
          check("beat_step", int'(m_step), idx);
        end else begin
          check("extra_beat", idx, exp_q.size() - 1);
        end
        out_ready = rnd ? 1'($urandom % 2) : 1'b1;
        if (pulse) begin
          drive_start(s, 1'($urandom % 2));
          init_cnt = CW'($urandom);
          init_phase = PW'($urandom);
        end
        if (m_valid && out_ready) begin
          if (idx == 1) begin s1c = int'(m_cnt); s1p = int'(m_phase); end
          lc = int'(m_cnt);
          lp = int'(m_phase);
          idx++;
        end
        @(negedge clk);
      end
    end
    if (!fin) begin
      n_total++;
      $display("FAIL run_timeout: got no done, expected done within 400 cycles");
      drive_start(s, 1'b0);
      return;
    end
    check("beat_count", idx, exp_q.size());
    check("cycle_found", int'(m_found), (exp_len != 0) ? 1 : 0);
    check("cycle_len", int'(m_len), exp_len);
    check("valid_low_in_fin", int'(m_valid), 0);
    // A start during the done cycle must not launch a new run.
    drive_start(s, pulse);
    @(negedge clk);
    drive_start(s, 1'b0);
    check("done_one_cycle", int'(m_done), 0);
    check("idle_busy", int'(m_busy), 0);
    check("idle_valid", int'(m_valid), 0);
    check("found_held", int'(m_found), (exp_len != 0) ? 1 : 0);
  endtask

  typedef struct {
    int ic; int ip; bit rnd; bit pulse; int len; int s1c; int s1p;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s1c, s1p, lc, lp;
    vecs[0] = '{ic: 0, ip: 0, rnd: 0, pulse: 0, len: 16, s1c: 1, s1p: 1};
    vecs[1] = '{ic: 7, ip: 3, rnd: 0, pulse: 0, len: 16, s1c: 0, s1p: 2};
    vecs[2] = '{ic: 3, ip: 2, rnd: 1, pulse: 0, len: 16, s1c: 3, s1p: 0};
    vecs[3] = '{ic: 5, ip: 1, rnd: 1, pulse: 1, len: 16, s1c: 5, s1p: 3};

    sel = 1'b0;
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    out_ready = 1'b0;
    init_cnt = '0;
    init_phase = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy1), 0);
    check("rst_valid", int'(valid1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_found", int'(found1), 0);
    check("rst_outs", int'({cnt1, ph1, step1, len1}), 0);
    check("rst_short_outs", int'({busy2, valid2, cnt2, ph2, step2, len2}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run(1'b0, vecs[i].ic, vecs[i].ip, 20, vecs[i].rnd, vecs[i].pulse, s1c, s1p, lc, lp);
      check("tbl_len", int'(len1), vecs[i].len);
      check("tbl_step1_cnt", s1c, vecs[i].s1c);
      check("tbl_step1_phase", s1p, vecs[i].s1p);
    end

    // Step limit reached before the trace closes.
    run(1'b1, 0, 0, 12, 1'b0, 1'b0, s1c, s1p, lc, lp);
    check("limit_last_cnt", lc, 6);
    check("limit_last_phase", lp, 2);
    check("limit_last_step", int'(step2), 11);
    check("limit_no_cycle", int'(found2), 0);

    for (int i = 0; i < 6; i++) begin
      run(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 20, 1'b1, 1'b1,
          s1c, s1p, lc, lp);
    end

    // Reset mid-run at step 5.
    sel = 1'b0;
    @(negedge clk);
    init_cnt = 3'd2;
    init_phase = 2'd1;
    out_ready = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 50 && step1 != 5'd5; cyc++) @(negedge clk);
    check("reached_step5", int'(step1), 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", int'(busy1), 0);
    check("abort_valid", int'(valid1), 0);
    check("abort_outs", int'({cnt1, ph1, step1, len1, found1}), 0);
    check("abort_no_done", int'(done1), 0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", int'({busy1, valid1, done1}), 0);
    run(1'b0, 2, 1, 20, 1'b0, 1'b0, s1c, s1p, lc, lp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
